// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//
// Contents:
//   - default geometry of the fetch-stage BTB (64-bit PC, 32 sets, 2 ways,
//     2-bit direction counters)
//   - derived widths (tag width, way-pointer width clamped to >= 1)
//   - counter constants: saturation value (all ones) and the weakly-taken
//     value (MSB set, rest zero), both as functions of the counter width
//   - a packed entry struct for the default geometry
//
// The top module is parameterised, so it derives its own widths from the
// helper functions below instead of the default-geometry localparams.
package btb_pkg;

   localparam int unsigned DEF_PC_W        = 64;
   localparam int unsigned DEF_OFFSET_BITS = 2;
   localparam int unsigned DEF_INDEX_BITS  = 5;
   localparam int unsigned DEF_WAYS        = 2;
   localparam int unsigned DEF_CTR_W       = 2;

   // Tag width: PC bits above the index field.
   function automatic int unsigned tag_width(input int unsigned pc_w,
                                             input int unsigned offset_bits,
                                             input int unsigned index_bits);
      return pc_w - offset_bits - index_bits;
   endfunction

   // Way-pointer width; a direct-mapped buffer still needs a 1-bit signal
   // to declare, even though it only ever holds 0.
   function automatic int unsigned way_width(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // Saturated (strongly taken) counter value: all ones.
   function automatic int unsigned ctr_max(input int unsigned ctr_w);
      return (ctr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ctr_w) - 32'd1);
   endfunction

   // Weakly-taken counter value: MSB set, remaining bits clear.
   function automatic int unsigned ctr_weak(input int unsigned ctr_w);
      return 32'd1 << (ctr_w - 1);
   endfunction

   localparam int unsigned TAG_W = tag_width(DEF_PC_W, DEF_OFFSET_BITS, DEF_INDEX_BITS);
   localparam int unsigned WAY_W = way_width(DEF_WAYS);

   // One BTB entry in the default geometry.
   typedef struct packed {
      logic                   valid;
      logic [TAG_W-1:0]       tag;
      logic [DEF_PC_W-1:0]    target;
      logic                   is_jump;
      logic [DEF_CTR_W-1:0]   ctr;
   } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next value of a saturating up/down direction counter.
//
// Ports:
//   ctr_i  in  CTR_W  current counter value
//   up_i   in  1      1 = branch taken (count up), 0 = not taken (count down)
//   ctr_o  out CTR_W  next value, clamped at all-ones and at zero
module btb_sat_counter #(
   parameter int unsigned CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             up_i,
   output logic [CTR_W-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (up_i) begin
         if (ctr_i != {CTR_W{1'b1}}) ctr_o = ctr_i + CTR_W'(1);
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
      end
   end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer for the fetch stage.
//
// Each set holds WAYS entries {valid, tag, target, is_jump, ctr} and one
// round-robin victim pointer. Lookups are registered (one-cycle latency) and
// read the array state from before the edge, so a same-edge update is not
// visible to the lookup launched at that edge. Updates from execute train
// counters on a hit and allocate on a taken/jump miss.
//
// Ports:
//   clk          in  1     clock, rising edge
//   rst          in  1     synchronous active-high reset: clears valid bits,
//                          victim pointers and the prediction outputs
//   en           in  1     lookup enable; when low the outputs hold
//   lookup_pc    in  PC_W  fetch PC to predict
//   flush        in  1     invalidate every entry (outputs not cleared)
//   upd_valid    in  1     update strobe from execute
//   upd_pc       in  PC_W  PC of the resolved branch/jump
//   upd_target   in  PC_W  resolved target
//   upd_taken    in  1     branch resolved taken
//   upd_is_jump  in  1     unconditional jump (implies taken)
//   pred_valid   out 1     registered hit
//   pred_taken   out 1     registered hit and (jump or counter MSB)
//   pred_target  out PC_W  registered target on hit, 0 on miss
module branch_target_buffer_sa
   import btb_pkg::*;
#(
   parameter int unsigned PC_W        = 64,
   parameter int unsigned OFFSET_BITS = 2,
   parameter int unsigned INDEX_BITS  = 5,
   parameter int unsigned WAYS        = 2,
   parameter int unsigned CTR_W       = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [PC_W-1:0] lookup_pc,
   input  logic            flush,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            upd_is_jump,
   output logic            pred_valid,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target
);

   localparam int unsigned SETS        = 1 << INDEX_BITS;
   localparam int unsigned ENTRY_TAG_W = tag_width(PC_W, OFFSET_BITS, INDEX_BITS);
   localparam int unsigned PTR_W       = way_width(WAYS);
   localparam int unsigned TAG_LSB     = OFFSET_BITS + INDEX_BITS;

   localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(ctr_weak(CTR_W));

   // Payload of one way; the valid bit lives in its own resettable array.
   typedef struct packed {
      logic [ENTRY_TAG_W-1:0] tag;
      logic [PC_W-1:0]        target;
      logic                   is_jump;
      logic [CTR_W-1:0]       ctr;
   } way_data_t;

   way_data_t        data_q  [SETS][WAYS];
   way_data_t        data_d  [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];
   logic [PTR_W-1:0] vptr_q  [SETS];
   logic [PTR_W-1:0] vptr_d  [SETS];

   logic            pred_valid_q,  pred_valid_d;
   logic            pred_taken_q,  pred_taken_d;
   logic [PC_W-1:0] pred_target_q, pred_target_d;

   // Alignment bits of both PCs never take part in index or tag.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{lookup_pc[OFFSET_BITS-1:0], upd_pc[OFFSET_BITS-1:0]};

   // ------------------------------------------------------------------
   // Lookup: tag compare against the pre-edge array contents.
   // ------------------------------------------------------------------
   logic [INDEX_BITS-1:0]  l_idx;
   logic [ENTRY_TAG_W-1:0] l_tag;
   logic                   l_hit;
   way_data_t              l_data;

   always_comb begin
      l_idx  = lookup_pc[TAG_LSB-1:OFFSET_BITS];
      l_tag  = lookup_pc[PC_W-1:TAG_LSB];
      l_hit  = 1'b0;
      l_data = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!l_hit && valid_q[l_idx][w] && (data_q[l_idx][w].tag == l_tag)) begin
            l_hit  = 1'b1;
            l_data = data_q[l_idx][w];
         end
      end
   end

   always_comb begin
      pred_valid_d  = pred_valid_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (en) begin
         pred_valid_d  = l_hit;
         pred_taken_d  = l_hit && (l_data.is_jump || l_data.ctr[CTR_W-1]);
         pred_target_d = l_hit ? l_data.target : '0;
      end
   end

   // ------------------------------------------------------------------
   // Update: hit detection, first free way, and counter training.
   // ------------------------------------------------------------------
   logic [INDEX_BITS-1:0]  u_idx;
   logic [ENTRY_TAG_W-1:0] u_tag;
   logic                   u_hit;
   logic [PTR_W-1:0]       u_way;
   logic                   u_free;
   logic [PTR_W-1:0]       u_free_way;
   logic [CTR_W-1:0]       u_ctr_cur;
   logic [CTR_W-1:0]       u_ctr_next;
   logic [PTR_W-1:0]       alloc_way;

   always_comb begin
      u_idx      = upd_pc[TAG_LSB-1:OFFSET_BITS];
      u_tag      = upd_pc[PC_W-1:TAG_LSB];
      u_hit      = 1'b0;
      u_way      = '0;
      u_free     = 1'b0;
      u_free_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!u_hit && valid_q[u_idx][w] && (data_q[u_idx][w].tag == u_tag)) begin
            u_hit = 1'b1;
            u_way = PTR_W'(w);
         end
         // Lowest-numbered invalid way wins the allocation.
         if (!u_free && !valid_q[u_idx][w]) begin
            u_free     = 1'b1;
            u_free_way = PTR_W'(w);
         end
      end
      u_ctr_cur = data_q[u_idx][u_way].ctr;
   end

   btb_sat_counter #(
      .CTR_W (CTR_W)
   ) u_sat_counter (
      .ctr_i (u_ctr_cur),
      .up_i  (upd_taken),
      .ctr_o (u_ctr_next)
   );

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      vptr_d    = vptr_q;
      alloc_way = u_free ? u_free_way : vptr_q[u_idx];

      if (upd_valid) begin
         if (u_hit) begin
            if (upd_is_jump) begin
               data_d[u_idx][u_way].target  = upd_target;
               data_d[u_idx][u_way].is_jump = 1'b1;
               data_d[u_idx][u_way].ctr     = CTR_MAX;
            end else begin
               if (upd_taken) data_d[u_idx][u_way].target = upd_target;
               data_d[u_idx][u_way].ctr = u_ctr_next;
            end
         end else if (upd_taken || upd_is_jump) begin
            // Round-robin pointer advances only when a valid way is evicted.
            if (!u_free) begin
               vptr_d[u_idx] = (WAYS == 1) ? '0 : vptr_q[u_idx] + PTR_W'(1);
            end
            valid_d[u_idx][alloc_way] = 1'b1;
            data_d[u_idx][alloc_way]  = '{tag:     u_tag,
                                          target:  upd_target,
                                          is_jump: upd_is_jump,
                                          ctr:     upd_is_jump ? CTR_MAX : CTR_WEAK};
         end
      end

      // Flush overrides any same-cycle allocation, leaving it invalid.
      if (flush) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_d[s] = '0;
            vptr_d[s]  = '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            vptr_q[s]  <= '0;
         end
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         valid_q       <= valid_d;
         vptr_q        <= vptr_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   // Payload is qualified by the valid bit, so it carries no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign pred_valid  = pred_valid_q;
   assign pred_taken  = pred_taken_q;
   assign pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Directed bench for branch_target_buffer_sa in its default geometry
// (64-bit PC, 2 offset bits, 32 sets, 2 ways, 2-bit counters).
// All PCs used in the replacement steps map to set 0.
module tb_branch_target_buffer_sa;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [63:0] lookup_pc;
   logic        flush;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic [63:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;
   logic        pred_valid;
   logic        pred_taken;
   logic [63:0] pred_target;

   int n_vec = 0;
   int n_err = 0;

   branch_target_buffer_sa dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .lookup_pc   (lookup_pc),
      .flush       (flush),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .upd_is_jump (upd_is_jump),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_target (pred_target)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("miscompare on %s", tag);
      end
   endtask

   // One-cycle update pulse.
   task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt,
                            input logic taken, input logic jump);
      upd_pc      = pc;
      upd_target  = tgt;
      upd_taken   = taken;
      upd_is_jump = jump;
      upd_valid   = 1'b1;
      tick();
      upd_valid   = 1'b0;
   endtask

   // Registered lookup with expected prediction.
   task automatic lookup_check(input string tag, input logic [63:0] pc,
                               input logic ev, input logic et, input logic [63:0] etgt);
      lookup_pc = pc;
      en        = 1'b1;
      tick();
      check({tag, ".valid"},  {63'd0, pred_valid}, {63'd0, ev});
      check({tag, ".taken"},  {63'd0, pred_taken}, {63'd0, et});
      check({tag, ".target"}, pred_target, etgt);
   endtask

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; en = 1'b0; lookup_pc = '0; flush = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_is_jump = 1'b0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("reset.valid",  {63'd0, pred_valid}, 64'd0);
      check("reset.taken",  {63'd0, pred_taken}, 64'd0);
      check("reset.target", pred_target, 64'd0);

      // Allocate and hit: ctr = 2'b10 -> taken
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      lookup_check("alloc_hit", 64'h1000, 1'b1, 1'b1, 64'h2000);

      // Counter training: 10 -> 01 -> 00
      do_update(64'h1000, 64'h9999, 1'b0, 1'b0);
      do_update(64'h1000, 64'h9999, 1'b0, 1'b0);
      lookup_check("train_down", 64'h1000, 1'b1, 1'b0, 64'h2000);
      // 00 -> 01 -> 10 -> 11
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      lookup_check("train_up", 64'h1000, 1'b1, 1'b1, 64'h2000);
      // Saturate at 11, then two not-taken: 11 -> 10 -> 01 (not taken)
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      do_update(64'h1000, 64'h2000, 1'b0, 1'b0);
      do_update(64'h1000, 64'h2000, 1'b0, 1'b0);
      lookup_check("saturate", 64'h1000, 1'b1, 1'b0, 64'h2000);

      // Associativity: 0x1080 fills way1, 0x1100 evicts way0 (0x1000), ptr -> 1
      do_update(64'h1080, 64'h2080, 1'b1, 1'b0);
      do_update(64'h1100, 64'h2100, 1'b1, 1'b0);
      lookup_check("evict_1000", 64'h1000, 1'b0, 1'b0, 64'h0);
      lookup_check("keep_1080",  64'h1080, 1'b1, 1'b1, 64'h2080);
      lookup_check("keep_1100",  64'h1100, 1'b1, 1'b1, 64'h2100);
      // Fourth allocation evicts way1 (0x1080), ptr -> 0
      do_update(64'h1180, 64'h2180, 1'b1, 1'b0);
      lookup_check("evict_1080", 64'h1080, 1'b0, 1'b0, 64'h0);
      lookup_check("hit_1180",   64'h1180, 1'b1, 1'b1, 64'h2180);
      lookup_check("still_1100", 64'h1100, 1'b1, 1'b1, 64'h2100);

      // Jump: evicts way0 (0x1100), ptr -> 1; stays taken after not-taken updates
      do_update(64'h3000, 64'h4000, 1'b1, 1'b1);
      lookup_check("jump_hit", 64'h3000, 1'b1, 1'b1, 64'h4000);
      do_update(64'h3000, 64'h5555, 1'b0, 1'b0);
      do_update(64'h3000, 64'h5555, 1'b0, 1'b0);
      do_update(64'h3000, 64'h5555, 1'b0, 1'b0);
      lookup_check("jump_sticky", 64'h3000, 1'b1, 1'b1, 64'h4000);

      // Not-taken miss: no allocation, nothing evicted
      do_update(64'h5000, 64'h6000, 1'b0, 1'b0);
      lookup_check("nt_miss",    64'h5000, 1'b0, 1'b0, 64'h0);
      lookup_check("nt_no_evict", 64'h1180, 1'b1, 1'b1, 64'h2180);

      // Same-edge collision: lookup sees pre-update state (0x1000 absent)
      upd_pc = 64'h1000; upd_target = 64'h2000; upd_taken = 1'b1; upd_is_jump = 1'b0;
      upd_valid = 1'b1; lookup_pc = 64'h1000; en = 1'b1;
      tick();
      upd_valid = 1'b0;
      check("collide.valid", {63'd0, pred_valid}, 64'd0);
      lookup_check("collide_next", 64'h1000, 1'b1, 1'b1, 64'h2000);

      // Flush with concurrent update; same-edge lookup still sees old state
      flush = 1'b1;
      upd_pc = 64'h6000; upd_target = 64'h7000; upd_taken = 1'b1; upd_is_jump = 1'b0;
      upd_valid = 1'b1; lookup_pc = 64'h3000;
      tick();
      flush = 1'b0; upd_valid = 1'b0;
      check("flush_edge.valid",  {63'd0, pred_valid}, 64'd1);
      check("flush_edge.target", pred_target, 64'h4000);
      lookup_check("flushed_3000", 64'h3000, 1'b0, 1'b0, 64'h0);
      lookup_check("flushed_6000", 64'h6000, 1'b0, 1'b0, 64'h0);
      lookup_check("flushed_1000", 64'h1000, 1'b0, 1'b0, 64'h0);

      // Hold with en=0; updates still proceed
      do_update(64'h1000, 64'h2000, 1'b1, 1'b0);
      lookup_check("pre_hold", 64'h1000, 1'b1, 1'b1, 64'h2000);
      en = 1'b0; lookup_pc = 64'h9000;
      do_update(64'h1080, 64'hAAA0, 1'b1, 1'b0);
      lookup_pc = 64'h1080;
      tick();
      check("hold.valid",  {63'd0, pred_valid}, 64'd1);
      check("hold.taken",  {63'd0, pred_taken}, 64'd1);
      check("hold.target", pred_target, 64'h2000);
      lookup_check("upd_while_off", 64'h1080, 1'b1, 1'b1, 64'hAAA0);

      // Reset during a lookup: outputs 0, entries gone
      lookup_pc = 64'h1000; en = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid.valid",  {63'd0, pred_valid}, 64'd0);
      check("rst_mid.taken",  {63'd0, pred_taken}, 64'd0);
      check("rst_mid.target", pred_target, 64'd0);
      lookup_check("rst_1000", 64'h1000, 1'b0, 1'b0, 64'h0);
      lookup_check("rst_1080", 64'h1080, 1'b0, 1'b0, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
